sum_result_fifo: RTL and testbench
==================================

SUM_RESULT_FIFO -- requirements
Module: sum_result_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0010: byte address of register 0.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, 2..16.
REQ-003 SHALL have port wb_clk_i  in  1: clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each: Wishbone strobe, cycle, write-enable.
REQ-006 SHALL have port wbs_sel_i  in  4: byte lane selects.
REQ-007 SHALL have port wbs_adr_i, wbs_dat_i  in  32 each: address, write data.
REQ-008 SHALL have port wbs_ack_o  out  1: acknowledge, registered.
REQ-009 SHALL have port wbs_dat_o  out  32: read data, registered.
REQ-010 SHALL have port sum_i  in  9: adder result {cout,sum[7:0]}.
REQ-011 SHALL have port sum_valid_i  in  1: push strobe, one push per cycle high.
REQ-012 SHALL have port irq_o  out  1: level interrupt.

Function
REQ-013 SHALL decode three 32-bit registers: DATA at BASE_ADDR+0, STATUS at +4, CTRL at +8; other addresses SHALL get no ack.
REQ-014 SHALL assert wbs_ack_o exactly one cycle, on the edge after stb&cyc&decode-hit with ack low; no ack the following cycle, so back-to-back transfers take two cycles each.
REQ-015 DATA read SHALL return {23'b0, head entry} and pop on the same edge ack rises; read when empty SHALL return 0 and not pop; DATA write SHALL be acked and ignored.
REQ-016 STATUS read SHALL return [4:0] count (0..DEPTH), [5] empty, [6] full, [7] overflow, others 0.
REQ-017 STATUS write with wbs_sel_i[0] and wbs_dat_i[7]=1 SHALL clear overflow; other bits read-only.
REQ-018 CTRL read SHALL return [0] irq_en, others 0; write with wbs_sel_i[0] SHALL load irq_en from wbs_dat_i[0], and wbs_dat_i[1]=1 SHALL flush (count, pointers to 0), bit 1 self-clearing, never read back.
REQ-019 sum_valid_i with FIFO not full SHALL store sum_i at tail and increment count on that edge.
REQ-020 sum_valid_i with FIFO full and no pop that cycle SHALL drop the value, leave contents unchanged, and set sticky overflow.
REQ-021 Push and pop on the same edge SHALL both take effect, count unchanged, including when full (no overflow); when empty the pop SHALL return 0 and the push SHALL be stored (count becomes 1).
REQ-022 Flush and push on the same edge: flush SHALL win, push discarded, overflow unaffected.
REQ-023 Overflow set and clear on the same edge: set SHALL win.
REQ-024 Pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO across wrap.
REQ-025 irq_o SHALL be registered, equal irq_en & (!empty | overflow), updated one cycle after the state change.
REQ-026 wbs_dat_o SHALL be 0 whenever wbs_ack_o is low.

Reset
REQ-027 On rst high, asynchronously: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, count=0, pointers=0, overflow=0, irq_en=0; storage contents not reset.
REQ-028 rst asserted mid-transfer SHALL abort it without ack; first cycle after release SHALL accept new transfers and pushes.

Verification
REQ-029 After reset, push 9'h0FF, 9'h1FE, 9'h005 -> STATUS reads 0x03; three DATA reads return 0xFF, 0x1FE, 0x005; STATUS then 0x20.
REQ-030 Push 9 values 1..9 at DEPTH=8 -> STATUS 0xC8; reads return 1..8; write STATUS 0x80 -> STATUS 0x20.
REQ-031 FIFO full, DATA read coincident with push of 9'h1AA -> returns oldest, count stays 8, overflow 0, 9'h1AA read last.
REQ-032 CTRL=1, push 9'h010 -> irq_o high one cycle after push edge; DATA read -> irq_o low one cycle after ack.
REQ-033 Four entries queued, write CTRL 0x3 coincident with push -> STATUS 0x20; DATA read returns 0; irq_o stays low.
REQ-034 Pushes of 20 values with interleaved reads across pointer wrap -> all returned in order; rst pulse mid-read -> no ack, STATUS 0x20 after release.

Source files
------------

// File: rtl/sum_result_fifo.sv
// Wishbone-readable FIFO that captures 9-bit adder results ({cout, sum}).
// Three registers: DATA (pop on read), STATUS (count/empty/full/overflow),
// CTRL (irq enable, self-clearing flush). Level interrupt when enabled and
// the FIFO holds data or has overflowed.
module sum_result_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0010,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [8:0]  sum_i,
  input  logic        sum_valid_i,
  output logic        irq_o
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthCnt = 5'(DEPTH);

  logic [8:0]      mem [DEPTH];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [4:0]      count;
  logic [4:0]      count_next;
  logic            overflow;
  logic            irq_en;

  logic [31:0] offset;
  logic        hit_data;
  logic        hit_status;
  logic        hit_ctrl;
  logic        req;
  logic        rd_req;
  logic        wr_req;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        flush;
  logic        ovf_set;
  logic        ovf_clr;
  logic [31:0] rd_data;
  logic        unused;

  // Write-data bits and byte lanes that no register field consumes.
  assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_dat_i[6:2]};

  // Address decode and transfer acceptance; ack low gates a new accept so
  // every transfer occupies two cycles.
  assign offset     = wbs_adr_i - BASE_ADDR;
  assign hit_data   = (offset == 32'd0);
  assign hit_status = (offset == 32'd4);
  assign hit_ctrl   = (offset == 32'd8);
  assign req        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (hit_data | hit_status | hit_ctrl);
  assign rd_req     = req & ~wbs_we_i;
  assign wr_req     = req & wbs_we_i;

  assign empty = (count == 5'd0);
  assign full  = (count == DepthCnt);

  // Reading DATA while empty returns zero and leaves the FIFO untouched.
  assign pop     = rd_req & hit_data & ~empty;
  assign flush   = wr_req & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
  // A same-edge pop frees the slot, so a full FIFO still accepts the push.
  assign push    = sum_valid_i & ~flush & (~full | pop);
  assign ovf_set = sum_valid_i & ~flush & full & ~pop;
  assign ovf_clr = wr_req & hit_status & wbs_sel_i[0] & wbs_dat_i[7];

  // Read-data mux, sampled on the accepting edge.
  always_comb begin
    rd_data = 32'd0;
    if (hit_data) begin
      rd_data = empty ? 32'd0 : {23'd0, mem[rd_ptr]};
    end else if (hit_status) begin
      rd_data = {24'd0, overflow, full, empty, count};
    end else if (hit_ctrl) begin
      rd_data = {31'd0, irq_en};
    end
  end

  // Occupancy next-state.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 5'd0;
    end else if (push && !pop) begin
      count_next = count + 5'd1;
    end else if (pop && !push) begin
      count_next = count - 5'd1;
    end
  end

  // Bus response: single-cycle ack, data forced to zero outside ack.
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_req ? rd_data : 32'd0;
    end
  end

  // FIFO pointers, count, sticky overflow and control state.
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PtrW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PtrW'(1);
        end
      end
      // Set wins over a coincident clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (wr_req && hit_ctrl && wbs_sel_i[0]) begin
        irq_en <= wbs_dat_i[0];
      end
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= sum_i;
    end
  end

  // Interrupt follows the registered state one cycle later.
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en & (~empty | overflow);
    end
  end

endmodule

// File: tb/tb_sum_result_fifo.sv
// Bench for sum_result_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and a random phase.
module tb_sum_result_fifo;

  localparam logic [31:0] Base  = 32'h3000_0010;
  localparam int unsigned Depth = 8;

  logic        wb_clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [8:0]  sum_i = 9'd0;
  logic        sum_valid_i = 1'b0;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;
  bit started = 0;
  bit rand_push = 0;

  sum_result_fifo #(
    .BASE_ADDR(Base),
    .DEPTH    (Depth)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .rst        (rst),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .sum_i      (sum_i),
    .sum_valid_i(sum_valid_i),
    .irq_o      (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0]  m_q[$];
  bit          m_ovf = 0;
  bit          m_en = 0;
  bit          m_ack = 0;
  bit          m_rd = 0;
  bit          m_irq = 0;
  logic [31:0] m_dat = 0;

  initial begin
    logic [31:0] off;
    logic [31:0] rdv;
    bit flush;
    bit clr;
    forever begin
      @(posedge wb_clk_i or posedge rst);
      if (rst) begin
        m_q.delete();
        m_ovf = 0; m_en = 0; m_ack = 0; m_rd = 0; m_irq = 0; m_dat = 0;
      end else begin
        flush = 0;
        clr = 0;
        rdv = 0;
        // Interrupt reflects the state before this edge.
        m_irq = m_en && (m_q.size() != 0 || m_ovf);
        off = wbs_adr_i - Base;
        if (wbs_stb_i && wbs_cyc_i && !m_ack && (off == 0 || off == 4 || off == 8)) begin
          m_ack = 1;
          m_rd = !wbs_we_i;
          if (!wbs_we_i) begin
            if (off == 0) begin
              if (m_q.size() > 0) rdv = {23'd0, m_q.pop_front()};
            end else if (off == 4) begin
              rdv = m_q.size();
              if (m_q.size() == 0) rdv += 32'h20;
              if (m_q.size() == Depth) rdv += 32'h40;
              if (m_ovf) rdv += 32'h80;
            end else begin
              rdv = {31'd0, m_en};
            end
          end else if (wbs_sel_i[0]) begin
            if (off == 4 && wbs_dat_i[7]) clr = 1;
            if (off == 8) begin
              m_en = wbs_dat_i[0];
              flush = wbs_dat_i[1];
            end
          end
          m_dat = rdv;
        end else begin
          m_ack = 0;
          m_rd = 0;
          m_dat = 0;
        end
        if (clr) m_ovf = 0;
        if (flush) m_q.delete();
        else if (sum_valid_i) begin
          if (m_q.size() < Depth) m_q.push_back(sum_i);
          else m_ovf = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (started) begin
        check("ack", {31'd0, wbs_ack_o}, {31'd0, m_ack});
        if (!m_ack || m_rd) check("dat_o", wbs_dat_o, m_dat);
        check("irq", {31'd0, irq_o}, {31'd0, m_irq});
      end
    end
  end

  // Background random pushes.
  initial begin
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (rand_push) begin
        sum_valid_i = ($urandom_range(0, 2) != 0);
        sum_i = 9'($urandom_range(0, 511));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc1();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    cyc1();
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; sum_valid_i = 0;
    cyc1();
    cyc1();
    rst = 1'b0;
  endtask

  task automatic push(input logic [8:0] v);
    sum_valid_i = 1'b1;
    sum_i = v;
    cyc1();
    sum_valid_i = 1'b0;
  endtask

  // One bus transfer with an optional push on the accepting edge.
  task automatic xfer(input logic we, input logic [31:0] off, input logic [31:0] wd,
                      input logic [3:0] sel, input logic pv, input logic [8:0] pd,
                      output logic [31:0] rd, output logic got);
    if (wbs_ack_o) cyc1();
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
    wbs_adr_i = Base + off; wbs_dat_i = wd; wbs_sel_i = sel;
    if (!rand_push) begin
      sum_valid_i = pv;
      sum_i = pd;
    end
    got = 0;
    rd = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      cyc1();
      if (i == 0 && !rand_push) sum_valid_i = 0;
      if (wbs_ack_o) begin
        got = 1;
        rd = wbs_dat_o;
      end
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic rd_reg(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic got;
    xfer(1'b0, off, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
    check({name, " ack"}, {31'd0, got}, 32'd1);
    if (got) check(name, rd, exp);
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] wd);
    logic [31:0] rd;
    logic got;
    xfer(1'b1, off, wd, 4'hf, 1'b0, 9'd0, rd, got);
    check("write ack", {31'd0, got}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        got;
    logic [8:0]  nxt;

    cyc1();
    cyc1();
    rst = 1'b0;
    started = 1;

    // Reset state.
    check("reset ack", {31'd0, wbs_ack_o}, 32'd0);
    check("reset irq", {31'd0, irq_o}, 32'd0);
    rd_reg("reset status", 32'd4, 32'h20);
    rd_reg("reset ctrl", 32'd8, 32'h0);

    // Three pushes then drain.
    push(9'h0FF); push(9'h1FE); push(9'h005);
    rd_reg("st3", 32'd4, 32'h03);
    rd_reg("d0", 32'd0, 32'h0FF);
    rd_reg("d1", 32'd0, 32'h1FE);
    rd_reg("d2", 32'd0, 32'h005);
    rd_reg("st empty", 32'd4, 32'h20);
    rd_reg("empty read", 32'd0, 32'h0);
    wr_reg(32'd0, 32'h1234);
    rd_reg("data write ignored", 32'd4, 32'h20);

    // Unmapped addresses are never acknowledged.
    xfer(1'b0, 32'hC, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
    check("no ack +C", {31'd0, got}, 32'd0);
    xfer(1'b0, 32'h100, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
    check("no ack +100", {31'd0, got}, 32'd0);

    // Overflow with nine pushes.
    do_reset();
    for (int i = 1; i <= 9; i++) push(9'(i));
    rd_reg("st ovf", 32'd4, 32'hC8);
    for (int i = 1; i <= 8; i++) rd_reg("ovf drain", 32'd0, 32'(i));
    rd_reg("st ovf empty", 32'd4, 32'hA0);
    wr_reg(32'd4, 32'h80);
    rd_reg("st cleared", 32'd4, 32'h20);

    // Full FIFO, read coincident with push.
    do_reset();
    for (int i = 0; i < 8; i++) push(9'(8'h11 + i));
    xfer(1'b0, 32'd0, 32'd0, 4'hf, 1'b1, 9'h1AA, rd, got);
    check("full rd+push", rd, 32'h11);
    rd_reg("full rd+push st", 32'd4, 32'h48);
    for (int i = 1; i < 8; i++) rd_reg("full tail", 32'd0, 32'(8'h11 + i));
    rd_reg("last 1AA", 32'd0, 32'h1AA);

    // Empty FIFO, read coincident with push.
    xfer(1'b0, 32'd0, 32'd0, 4'hf, 1'b1, 9'h077, rd, got);
    check("empty rd+push", rd, 32'h0);
    rd_reg("empty rd+push st", 32'd4, 32'h01);
    rd_reg("empty rd+push val", 32'd0, 32'h077);

    // Interrupt timing.
    do_reset();
    wr_reg(32'd8, 32'h1);
    cyc1();
    push(9'h010);
    check("irq at push", {31'd0, irq_o}, 32'd0);
    cyc1();
    check("irq after push", {31'd0, irq_o}, 32'd1);
    rd_reg("irq data", 32'd0, 32'h010);
    check("irq at ack", {31'd0, irq_o}, 32'd1);
    cyc1();
    check("irq after ack", {31'd0, irq_o}, 32'd0);

    // Flush coincident with push.
    do_reset();
    for (int i = 0; i < 4; i++) push(9'(i + 1));
    xfer(1'b1, 32'd8, 32'h3, 4'h1, 1'b1, 9'h155, rd, got);
    check("flush ack", {31'd0, got}, 32'd1);
    check("flush irq0", {31'd0, irq_o}, 32'd0);
    rd_reg("flush st", 32'd4, 32'h20);
    check("flush irq1", {31'd0, irq_o}, 32'd0);
    rd_reg("flush data", 32'd0, 32'h0);
    rd_reg("ctrl readback", 32'd8, 32'h1);
    check("flush irq2", {31'd0, irq_o}, 32'd0);

    // Twenty values through a depth-8 FIFO with interleaved reads.
    do_reset();
    nxt = 9'h40;
    for (int i = 0; i < 20; i++) begin
      push(9'(9'h40 + i));
      if (i >= 3) begin
        rd_reg("wrap order", 32'd0, {23'd0, nxt});
        nxt++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      rd_reg("wrap drain", 32'd0, {23'd0, nxt});
      nxt++;
    end
    rd_reg("wrap st", 32'd4, 32'h20);

    // Random traffic; the per-cycle model compare does the checking.
    rand_push = 1;
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [31:0] wd;
      r = $urandom_range(0, 9);
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) wd[1] = 1'b0;
      if (r <= 4) xfer(1'b0, 32'd0, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
      else if (r == 5) xfer(1'b0, 32'd4, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
      else if (r == 6) xfer(1'b0, 32'd8, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
      else if (r == 7) xfer(1'b1, 32'd8, wd, 4'($urandom), 1'b0, 9'd0, rd, got);
      else if (r == 8) xfer(1'b1, 32'd4, wd, 4'($urandom), 1'b0, 9'd0, rd, got);
      else xfer(1'b0, 32'hC, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
      repeat ($urandom_range(0, 2)) cyc1();
    end
    rand_push = 0;
    sum_valid_i = 0;
    cyc1();

    // Reset pulse in the middle of a DATA read.
    push(9'h0AB);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = Base; wbs_sel_i = 4'hf;
    #2;
    rst = 1'b1;
    #1;
    check("rst mid ack", {31'd0, wbs_ack_o}, 32'd0);
    cyc1();
    check("rst hold ack", {31'd0, wbs_ack_o}, 32'd0);
    wbs_stb_i = 0; wbs_cyc_i = 0;
    rst = 1'b0;
    xfer(1'b0, 32'd4, 32'd0, 4'hf, 1'b0, 9'd0, rd, got);
    check("post-rst first accept", {31'd0, got}, 32'd1);
    check("post-rst st", rd, 32'h20);

    cyc1();
    cyc1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
